// File: rtl/tmnt_pkg.sv
// Shared definitions for the tile ROM arbitration block: default widths,
// the starvation limit and the arbiter state encoding.
package tmnt_pkg;

  localparam int TMNT_ADDR_W     = 18;
  localparam int TMNT_DATA_W     = 32;
  localparam int TMNT_STARVE_MAX = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    VID_WAIT = 2'd1,
    CPU_WAIT = 2'd2,
    CPU_HOLD = 2'd3
  } arb_state_e;

endpackage

// File: rtl/tile_fetch_cache.sv
// One-entry cache of the most recent video tile fetch. The lookup compare is
// combinational so a hit can be answered in the cycle after the request.
module tile_fetch_cache
  import tmnt_pkg::*;
#(
  parameter int ADDR_W = TMNT_ADDR_W,
  parameter int DATA_W = TMNT_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] lookup_addr_i,
  input  logic              fill_i,
  input  logic [ADDR_W-1:0] fill_addr_i,
  input  logic [DATA_W-1:0] fill_data_i,
  output logic              hit_o,
  output logic [DATA_W-1:0] data_o
);

  logic [ADDR_W-1:0] last_addr_q;
  logic [DATA_W-1:0] last_data_q;
  logic              last_valid_q;

  // Hold the address/data of the last completed video fetch.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_addr_q  <= {ADDR_W{1'b0}};
      last_data_q  <= {DATA_W{1'b0}};
      last_valid_q <= 1'b0;
    end else if (fill_i) begin
      last_addr_q  <= fill_addr_i;
      last_data_q  <= fill_data_i;
      last_valid_q <= 1'b1;
    end else begin
      last_valid_q <= last_valid_q;
    end
  end

  // Hit when the entry is valid and the address matches exactly.
  always_comb begin
    hit_o  = last_valid_q && (lookup_addr_i == last_addr_q);
    data_o = last_data_q;
  end

endmodule

// File: rtl/tile_rom_arbiter.sv
// Arbitrates the tile ROM between video tile fetches and CPU readback.
// Video has priority unless the CPU has waited through STARVE_MAX video
// grants; repeated video fetches of the last address are served from a
// one-entry cache without touching memory.
module tile_rom_arbiter
  import tmnt_pkg::*;
#(
  parameter int ADDR_W     = TMNT_ADDR_W,
  parameter int DATA_W     = TMNT_DATA_W,
  parameter int STARVE_MAX = TMNT_STARVE_MAX
) (
  input  logic              clk_main,
  input  logic              nRES,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_overrun,
  input  logic              cpu_ncs,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ndtac,
  output logic [DATA_W-1:0] cpu_data,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  arb_state_e        state_q;
  logic              vid_pend_q;
  logic [ADDR_W-1:0] vid_addr_q;
  logic [CNT_W-1:0]  starve_q;
  logic              mem_req_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              vid_valid_q;
  logic [DATA_W-1:0] vid_data_q;
  logic              vid_overrun_q;
  logic              cpu_ndtac_q;
  logic [DATA_W-1:0] cpu_data_q;

  logic              cache_hit_s;
  logic [DATA_W-1:0] cache_data_s;
  logic              cache_fill_s;
  logic              vid_miss_s;
  logic              cpu_pend_s;
  logic              grant_vid_s;
  logic              grant_cpu_s;
  logic              starved_s;

  tile_fetch_cache #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_cache (
    .clk_i         (clk_main),
    .rst_ni        (nRES),
    .lookup_addr_i (vid_addr),
    .fill_i        (cache_fill_s),
    .fill_addr_i   (mem_addr_q),
    .fill_data_i   (mem_rdata),
    .hit_o         (cache_hit_s),
    .data_o        (cache_data_s)
  );

  // Request qualification and the IDLE grant decision.
  always_comb begin
    vid_miss_s   = vid_req && !cache_hit_s;
    cpu_pend_s   = !cpu_ncs && cpu_ndtac_q && (state_q != CPU_HOLD);
    starved_s    = (starve_q == CNT_W'(STARVE_MAX));
    cache_fill_s = (state_q == VID_WAIT) && mem_ack;
    grant_vid_s  = 1'b0;
    grant_cpu_s  = 1'b0;
    if (state_q == IDLE) begin
      if (vid_pend_q && cpu_pend_s) begin
        grant_cpu_s = starved_s;
        grant_vid_s = !starved_s;
      end else if (vid_pend_q) begin
        grant_vid_s = 1'b1;
      end else if (cpu_pend_s) begin
        grant_cpu_s = 1'b1;
      end else begin
        grant_vid_s = 1'b0;
      end
    end else begin
      grant_cpu_s = 1'b0;
    end
  end

  // Arbiter FSM with registered memory, video and CPU outputs.
  always_ff @(posedge clk_main) begin
    if (!nRES) begin
      state_q       <= IDLE;
      vid_pend_q    <= 1'b0;
      vid_addr_q    <= {ADDR_W{1'b0}};
      starve_q      <= {CNT_W{1'b0}};
      mem_req_q     <= 1'b0;
      mem_addr_q    <= {ADDR_W{1'b0}};
      vid_valid_q   <= 1'b0;
      vid_data_q    <= {DATA_W{1'b0}};
      vid_overrun_q <= 1'b0;
      cpu_ndtac_q   <= 1'b1;
      cpu_data_q    <= {DATA_W{1'b0}};
    end else begin
      vid_valid_q <= 1'b0;

      // A request being granted this cycle is no longer overwritable.
      if (vid_miss_s) begin
        vid_pend_q <= 1'b1;
        vid_addr_q <= vid_addr;
        if (vid_pend_q && !grant_vid_s) begin
          vid_overrun_q <= 1'b1;
        end
      end else if (grant_vid_s) begin
        vid_pend_q <= 1'b0;
      end else begin
        vid_pend_q <= vid_pend_q;
      end

      // Cache hits answer in any state; a simultaneous fill return below wins.
      if (vid_req && cache_hit_s) begin
        vid_valid_q <= 1'b1;
        vid_data_q  <= cache_data_s;
      end

      case (state_q)
        IDLE: begin
          if (grant_vid_s) begin
            mem_req_q  <= 1'b1;
            mem_addr_q <= vid_addr_q;
            state_q    <= VID_WAIT;
            if (cpu_pend_s && !starved_s) begin
              starve_q <= starve_q + CNT_W'(1);
            end
          end else if (grant_cpu_s) begin
            mem_req_q  <= 1'b1;
            mem_addr_q <= cpu_addr;
            starve_q   <= {CNT_W{1'b0}};
            state_q    <= CPU_WAIT;
          end
        end
        VID_WAIT: begin
          if (mem_ack) begin
            vid_data_q  <= mem_rdata;
            vid_valid_q <= 1'b1;
            mem_req_q   <= 1'b0;
            state_q     <= IDLE;
          end
        end
        CPU_WAIT: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            if (!cpu_ncs) begin
              cpu_data_q  <= mem_rdata;
              cpu_ndtac_q <= 1'b0;
              state_q     <= CPU_HOLD;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        CPU_HOLD: begin
          if (cpu_ncs) begin
            cpu_ndtac_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          mem_req_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign vid_valid   = vid_valid_q;
  assign vid_data    = vid_data_q;
  assign vid_overrun = vid_overrun_q;
  assign cpu_ndtac   = cpu_ndtac_q;
  assign cpu_data    = cpu_data_q;

endmodule

// File: doc/tile_rom_arbiter.md
TILE_ROM_ARBITER -- requirements
Module: tile_rom_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 18, giving the tile ROM word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, giving the tile ROM data width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, giving the maximum number of consecutive video grants while a CPU access waits.
REQ-004 clk_main  in  1  single clock; all logic is clocked on its rising edge.
REQ-005 nRES  in  1  reset, synchronous, active-low.
REQ-006 vid_req  in  1  one-cycle pulse requesting a video tile fetch.
REQ-007 vid_addr  in  ADDR_W  fetch address, sampled when vid_req=1.
REQ-008 vid_valid  out  1  one-cycle pulse marking vid_data valid.
REQ-009 vid_data  out  DATA_W  returned tile ROM word.
REQ-010 vid_overrun  out  1  sticky flag: a video request was overwritten before being granted.
REQ-011 cpu_ncs  in  1  active-low CPU ROM-readback select (RMRD path), held level.
REQ-012 cpu_addr  in  ADDR_W  CPU readback address, stable while cpu_ncs=0.
REQ-013 cpu_ndtac  out  1  active-low data acknowledge to the CPU.
REQ-014 cpu_data  out  DATA_W  CPU readback word.
REQ-015 mem_req  out  1  memory request, held until acknowledged.
REQ-016 mem_addr  out  ADDR_W  memory address, stable while mem_req=1.
REQ-017 mem_ack  in  1  one-cycle pulse; mem_rdata is valid in the same cycle.
REQ-018 mem_rdata  in  DATA_W  memory read data.

Function
REQ-019 FSM states SHALL be IDLE, VID_WAIT, CPU_WAIT and CPU_HOLD.
REQ-020 On vid_req=1, the block SHALL set vid_pend and latch vid_addr into vid_addr_q.
REQ-021 Overrun: if vid_req=1 while vid_pend=1 and the pending request is not yet granted, the block SHALL set vid_overrun=1 (sticky) and the new address SHALL replace the old one.
REQ-022 Cache hit: on vid_req with vid_addr equal to last_addr and last_valid=1, the block SHALL assert vid_valid in the next cycle with last_data, SHALL NOT set vid_pend, and SHALL issue no memory access; this SHALL apply in every FSM state.
REQ-023 A CPU access SHALL become pending when cpu_ncs=0, cpu_ndtac=1 and the FSM is not in CPU_HOLD.
REQ-024 In IDLE, if only one of the two requests is pending, that request SHALL be granted.
REQ-025 In IDLE, if both requests are pending, video SHALL be granted unless starve_cnt equals STARVE_MAX, in which case CPU SHALL be granted.
REQ-026 starve_cnt SHALL increment, saturating at STARVE_MAX, on each video grant made while a CPU access is pending.
REQ-027 starve_cnt SHALL clear on each CPU grant.
REQ-028 Grant: in the cycle after the grant decision, the block SHALL assert mem_req=1 with the granted address and move to VID_WAIT or CPU_WAIT; a video grant SHALL clear vid_pend.
REQ-029 VID_WAIT: on mem_ack, the block SHALL register vid_data=mem_rdata, pulse vid_valid for 1 cycle, load last_addr and last_data, set last_valid=1, drop mem_req in the next cycle, and return to IDLE.
REQ-030 CPU_WAIT: on mem_ack, the block SHALL register cpu_data=mem_rdata, drive cpu_ndtac=0 in the next cycle, drop mem_req, and go to CPU_HOLD; CPU reads SHALL NOT update the cache.
REQ-031 CPU_HOLD: cpu_ndtac SHALL stay 0 until cpu_ncs=1, then the block SHALL set cpu_ndtac=1 in the next cycle and return to IDLE; video requests SHALL keep queuing meanwhile.
REQ-032 If cpu_ncs rises during CPU_WAIT, the block SHALL complete the memory access, discard the data, keep cpu_ndtac=1, and return to IDLE.
REQ-033 mem_ack received in IDLE or CPU_HOLD SHALL be ignored.
REQ-034 Latency without contention: mem_req SHALL rise 2 cycles after vid_req, and vid_valid SHALL rise 1 cycle after mem_ack.

Reset
REQ-035 With nRES=0 at a clock edge, the block SHALL enter IDLE with mem_req=0, mem_addr=0, vid_valid=0, vid_data=0, vid_overrun=0, cpu_ndtac=1, cpu_data=0, vid_pend=0, starve_cnt=0, last_valid=0.
REQ-036 Reset mid-access SHALL abandon the access; a stale mem_ack after reset SHALL be ignored per REQ-033.

Structure
REQ-037 The FSM state enum and the default ADDR_W, DATA_W and STARVE_MAX values SHALL reside in the shared package tmnt_pkg.
REQ-038 The block SHALL contain one sub-module, tile_fetch_cache, holding last_addr, last_data and last_valid and performing the hit compare.

Verification
REQ-039 Single video fetch: vid_req with addr 0x01234 and mem_ack 3 cycles after mem_req, rdata 0xDEADBEEF -> mem_addr=0x01234, vid_valid one cycle with vid_data=0xDEADBEEF.
REQ-040 Cache hit: repeat vid_req at 0x01234 -> vid_valid the next cycle with 0xDEADBEEF and mem_req stays 0.
REQ-041 CPU read: cpu_ncs=0 at addr 0x3FFFF, rdata 0x12345678 -> cpu_ndtac=0 with cpu_data=0x12345678 held until cpu_ncs=1, then cpu_ndtac=1 one cycle later.
REQ-042 Starvation: CPU pending plus continuous video misses -> CPU granted after exactly 4 video grants.
REQ-043 Overrun: two vid_req (0x00010, then 0x00020) during CPU_WAIT -> vid_overrun=1 and only 0x00020 is fetched.
REQ-044 Reset during VID_WAIT, then a late mem_ack -> all outputs at reset values and no vid_valid.
